// File: rtl/akp_line_rx.sv
// AKP line receiver: checks sop/eop framing and line length, buffers tagged
// words in a FIFO and presents them with the six 32-bit channels unpacked.
module akp_line_rx #(
    parameter int DATA_W  = 192,
    parameter int LEN_W   = 12,
    parameter int FIFO_AW = 4
) (
    input  logic                clk,
    input  logic                sbros_n,
    input  logic                ink_i,
    input  logic                data_valid,
    input  logic                sop,
    input  logic                eop,
    input  logic [DATA_W-1:0]   din,
    input  logic [LEN_W-1:0]    L_stroke_1,
    input  logic                out_ready,
    output logic                out_valid,
    output logic                out_sop,
    output logic                out_eop,
    output logic [31:0]         out_up_re,
    output logic [31:0]         out_up_im,
    output logic [31:0]         out_dn_re,
    output logic [31:0]         out_dn_im,
    output logic [31:0]         out_pel_re,
    output logic [31:0]         out_pel_im,
    output logic                line_done,
    output logic [LEN_W-1:0]    line_len,
    output logic                err_len,
    output logic                err_frame,
    output logic                err_ovf,
    output logic [FIFO_AW:0]    fifo_level
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t state, state_nxt;

    logic [DATA_W+1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   pending;
    logic [DATA_W-1:0]  out_word;
    logic               full, xfer, load, can_wr;

    logic [LEN_W-1:0]   count, len_lat, cnt_sat, cnt_nxt, lat_nxt;
    logic               start, want_wr, drop_word, frame_err, ovf, wr_en;
    logic               end_line, len_bad, cnt_upd;

    // fifo_level counts the word held in the output register as well, so the
    // whole buffer (memory + output register) holds at most DEPTH words.
    assign full    = (fifo_level == DEPTH_L);
    assign xfer    = out_valid & out_ready;
    assign pending = fifo_level - (FIFO_AW + 1)'(out_valid);
    assign load    = (pending != '0) & (~out_valid | xfer);
    assign can_wr  = ~full | xfer;
    assign cnt_sat = (count == '1) ? count : count + 1'b1;

    always_ff @(posedge clk) begin
        if (!sbros_n || ink_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (end_line)
            state_nxt = IDLE;
        else if (ovf)
            state_nxt = DROP;
        else if (want_wr)
            state_nxt = RECV;
    end

    always_comb begin
        start     = 1'b0;
        want_wr   = 1'b0;
        drop_word = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE: if (data_valid) begin
                if (sop) begin
                    want_wr = 1'b1;
                    start   = 1'b1;
                end else begin
                    frame_err = 1'b1;
                end
            end
            RECV: if (data_valid) begin
                want_wr = 1'b1;
                if (sop) begin
                    start     = 1'b1;
                    frame_err = 1'b1;
                end
            end
            DROP: if (data_valid) drop_word = 1'b1;
            default: ;
        endcase
        ovf      = want_wr & ~can_wr;
        wr_en    = want_wr & can_wr & sbros_n & ~ink_i;
        end_line = data_valid & eop & (want_wr | drop_word);
        cnt_upd  = want_wr | drop_word;
        cnt_nxt  = start ? LEN_W'(1) : cnt_sat;
        lat_nxt  = start ? L_stroke_1 : len_lat;
        len_bad  = (state == DROP) | ovf |
                   ((lat_nxt != '0) && (cnt_nxt != lat_nxt));
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {sop, eop, din};
    end

    always_ff @(posedge clk) begin
        if (!sbros_n || ink_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_word   <= '0;
            count      <= '0;
            len_lat    <= '0;
            line_done  <= 1'b0;
            err_len    <= 1'b0;
            err_frame  <= 1'b0;
            err_ovf    <= 1'b0;
            if (!sbros_n)
                line_len <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            case ({wr_en, xfer})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (load) begin
                {out_sop, out_eop, out_word} <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            if (cnt_upd) begin
                count   <= cnt_nxt;
                len_lat <= lat_nxt;
            end
            line_done <= end_line;
            err_len   <= end_line & len_bad;
            err_frame <= frame_err;
            if (ovf)
                err_ovf <= 1'b1;
            if (end_line)
                line_len <= cnt_nxt;
        end
    end

    assign out_up_re  = out_word[191:160];
    assign out_up_im  = out_word[159:128];
    assign out_dn_re  = out_word[127:96];
    assign out_dn_im  = out_word[95:64];
    assign out_pel_re = out_word[63:32];
    assign out_pel_im = out_word[31:0];

endmodule
